// File: rtl/shared_buf_arbiter.sv
// Round-robin grant/release arbiter for a single-ported shared resource.
// Requesters pulse req/rel. Exactly one owner holds a registered one-hot grant,
// and a hold watchdog revokes ownership from an owner that never releases.
module shared_buf_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int HOLD_TIMEOUT = 4096,
  parameter int CNT_WIDTH    = 16
) (
  input  logic               clk_int,
  input  logic               rst_int,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] rel,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic [2:0]         owner_id,
  output logic [NUM_REQ-1:0] pending,
  output logic               timeout_pulse,
  output logic [7:0]         timeout_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    GAP     = 2'd2
  } state_t;

  localparam bit                   WDOG_EN   = (HOLD_TIMEOUT != 0);
  // Last counter value an owner may reach before the grant is pulled.
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = WDOG_EN ? CNT_WIDTH'(HOLD_TIMEOUT - 1) : '0;
  localparam logic [2:0]           LAST_IDX  = 3'(NUM_REQ - 1);
  localparam logic [3:0]           NUM_REQ_W = 4'(NUM_REQ);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   pending_q, pending_d;
  logic [2:0]           owner_q, owner_d;
  logic [2:0]           ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tpulse_q, tpulse_d;
  logic [7:0]           tcount_q, tcount_d;

  logic [NUM_REQ-1:0]   cand;
  logic [7:0]           cand_ext;
  logic                 win_found;
  logic [2:0]           win_idx;
  logic [NUM_REQ-1:0]   win_onehot;
  logic                 owner_rel;

  assign cand     = pending_q | req;
  assign cand_ext = 8'(cand);
  // grant_q is only non-zero in GRANTED, so masking with it isolates the owner.
  assign owner_rel = |(rel & grant_q);

  // Round-robin search: first candidate at or above the pointer, wrapping to 0.
  always_comb begin
    logic [3:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + 4'(k);
      if (idx >= NUM_REQ_W) idx = idx - NUM_REQ_W;
      if (!win_found && cand_ext[idx[2:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[2:0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_idx == 3'(gi));
    end
  endgenerate

  // Next-state and output logic for the IDLE/GRANTED/GAP arbiter FSM.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    tpulse_d  = 1'b0;
    tcount_d  = tcount_q;
    // New requests latch in every state; the current owner's own re-request is dropped.
    pending_d = pending_q | (req & ~grant_q);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (win_found) begin
          grant_d   = win_onehot;
          owner_d   = win_idx;
          ptr_d     = (win_idx == LAST_IDX) ? 3'd0 : win_idx + 3'd1;
          pending_d = pending_d & ~win_onehot;
          state_d   = GRANTED;
        end
      end
      GRANTED: begin
        cnt_d = cnt_q + 1'b1;
        if (owner_rel) begin
          // A release in the same cycle as the watchdog expiry takes priority.
          grant_d = '0;
          state_d = GAP;
        end else if (WDOG_EN && (cnt_q == HOLD_LAST)) begin
          grant_d  = '0;
          tpulse_d = 1'b1;
          tcount_d = (tcount_q != 8'hFF) ? tcount_q + 8'd1 : tcount_q;
          state_d  = GAP;
        end
      end
      GAP: begin
        // Dead cycle so the old owner sees grant low before a new owner sees it high.
        grant_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_int) begin
    if (rst_int) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      pending_q <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      tpulse_q  <= 1'b0;
      tcount_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pending_q <= pending_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      tpulse_q  <= tpulse_d;
      tcount_q  <= tcount_d;
    end
  end

  assign grant         = grant_q;
  assign busy          = |grant_q;
  assign owner_id      = owner_q;
  assign pending       = pending_q;
  assign timeout_pulse = tpulse_q;
  assign timeout_count = tcount_q;

endmodule

// File: tb/tb_shared_buf_arbiter.sv
// Scoreboard bench for shared_buf_arbiter: directed 2-requester scenarios with
// per-cycle expected outputs, plus a random 4-requester run checking invariants.
module tb_shared_buf_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 2-requester DUT with a short watchdog
  logic       rst = 1'b1;
  logic [1:0] req = '0, rel = '0, grant, pending;
  logic       busy, tpulse;
  logic [2:0] owner;
  logic [7:0] tcount;

  // 4-requester DUT for the random run
  logic       rst2 = 1'b1;
  logic [3:0] req2 = '0, rel2 = '0, grant2, pending2;
  logic       busy2, tpulse2;
  logic [2:0] owner2;
  logic [7:0] tcount2;

  shared_buf_arbiter #(.NUM_REQ(2), .HOLD_TIMEOUT(16), .CNT_WIDTH(16)) dut (
    .clk_int(clk), .rst_int(rst), .req(req), .rel(rel), .grant(grant), .busy(busy),
    .owner_id(owner), .pending(pending), .timeout_pulse(tpulse), .timeout_count(tcount));

  shared_buf_arbiter #(.NUM_REQ(4), .HOLD_TIMEOUT(16), .CNT_WIDTH(16)) dut4 (
    .clk_int(clk), .rst_int(rst2), .req(req2), .rel(rel2), .grant(grant2), .busy(busy2),
    .owner_id(owner2), .pending(pending2), .timeout_pulse(tpulse2), .timeout_count(tcount2));

  int n_tests = 0;
  int n_fail  = 0;
  int step_no = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         idx;
    logic [1:0] grant;
    logic [2:0] owner;
    logic [1:0] pending;
    logic       tpulse;
    logic [7:0] tcount;
  } exp_t;

  exp_t sb[$];

  // Drive one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic step(input logic rs, input logic [1:0] rq, input logic [1:0] rl,
                      input logic [1:0] eg, input logic [2:0] eo, input logic [1:0] ep,
                      input logic et, input logic [7:0] ec);
    exp_t e;
    @(negedge clk);
    rst = rs; req = rq; rel = rl;
    step_no++;
    e.idx = step_no; e.grant = eg; e.owner = eo; e.pending = ep; e.tpulse = et; e.tcount = ec;
    sb.push_back(e);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("grant@%0d", e.idx),   32'(grant),   32'(e.grant));
      chk($sformatf("owner@%0d", e.idx),   32'(owner),   32'(e.owner));
      chk($sformatf("pending@%0d", e.idx), 32'(pending), 32'(e.pending));
      chk($sformatf("busy@%0d", e.idx),    32'(busy),    32'(|e.grant));
      chk($sformatf("tpulse@%0d", e.idx),  32'(tpulse),  32'(e.tpulse));
      chk($sformatf("tcount@%0d", e.idx),  32'(tcount),  32'(e.tcount));
      $display("[TB] step %0d grant=%b owner=%0d pending=%b tpulse=%b tcount=%0d",
               e.idx, grant, owner, pending, tpulse, tcount);
    end
  end

  initial begin
    logic [7:0] exp_tc;
    logic [7:0] prev_tc2;

    // Reset
    step(1, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0);
    step(1, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0);
    repeat (3) step(0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0);

    // Single request from index 1, one-cycle latency, then release
    step(0, 2'b10, 2'b00, 2'b10, 1, 2'b00, 0, 0);
    repeat (5) step(0, 2'b00, 2'b00, 2'b10, 1, 2'b00, 0, 0);
    step(0, 2'b00, 2'b10, 2'b00, 1, 2'b00, 0, 0);   // -> GAP
    step(0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0);   // -> IDLE
    step(0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0);

    // Simultaneous requests: pointer is back at 0, so index 0 wins
    step(0, 2'b11, 2'b00, 2'b01, 0, 2'b10, 0, 0);
    repeat (2) step(0, 2'b00, 2'b00, 2'b01, 0, 2'b10, 0, 0);
    step(0, 2'b00, 2'b01, 2'b00, 0, 2'b10, 0, 0);   // rel[0] -> GAP
    step(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 0, 0);   // -> IDLE
    step(0, 2'b00, 2'b00, 2'b10, 1, 2'b00, 0, 0);   // pending index 1 granted
    step(0, 2'b00, 2'b10, 2'b00, 1, 2'b00, 0, 0);   // rel[1]
    step(0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0);
    step(0, 2'b11, 2'b00, 2'b01, 0, 2'b10, 0, 0);   // pointer wrapped: index 0 again

    // While 0 owns: non-owner rel ignored, owner re-request dropped,
    // then release lands on the watchdog's last cycle: no timeout
    step(0, 2'b00, 2'b10, 2'b01, 0, 2'b10, 0, 0);
    step(0, 2'b01, 2'b00, 2'b01, 0, 2'b10, 0, 0);
    repeat (13) step(0, 2'b00, 2'b00, 2'b01, 0, 2'b10, 0, 0);
    step(0, 2'b00, 2'b01, 2'b00, 0, 2'b10, 0, 0);
    step(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 0, 0);

    // Index 1 granted from pending and never releases: watchdog revokes after 16 cycles
    step(0, 2'b00, 2'b00, 2'b10, 1, 2'b00, 0, 0);
    repeat (15) step(0, 2'b00, 2'b00, 2'b10, 1, 2'b00, 0, 0);
    step(0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 1, 1);
    step(0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 1);
    repeat (3) step(0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 1);

    // Reset while index 1 owns and index 0 is pending
    step(0, 2'b10, 2'b00, 2'b10, 1, 2'b00, 0, 1);
    step(0, 2'b01, 2'b00, 2'b10, 1, 2'b01, 0, 1);
    step(1, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0);
    step(0, 2'b10, 2'b00, 2'b10, 1, 2'b00, 0, 0);
    step(0, 2'b00, 2'b10, 2'b00, 1, 2'b00, 0, 0);
    step(0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0);

    // Same-index req and rel in IDLE: req wins
    step(0, 2'b01, 2'b01, 2'b01, 0, 2'b00, 0, 0);
    step(0, 2'b00, 2'b01, 2'b00, 0, 2'b00, 0, 0);
    step(0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0);

    // Repeated watchdog revokes until timeout_count saturates
    exp_tc = 8'd0;
    for (int n = 0; n < 257; n++) begin
      step(0, 2'b01, 2'b00, 2'b01, 0, 2'b00, 0, exp_tc);
      repeat (15) step(0, 2'b00, 2'b00, 2'b01, 0, 2'b00, 0, exp_tc);
      exp_tc = (exp_tc == 8'hFF) ? exp_tc : exp_tc + 8'd1;
      step(0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 1, exp_tc);
      step(0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, exp_tc);
    end
    @(posedge clk); #2;
    chk("sb_drain", 32'(sb.size()), 32'd0);

    // Random 4-requester run: grant stays onehot0 and consistent with the other outputs
    @(negedge clk); rst2 = 1'b0;
    prev_tc2 = 8'd0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      req2 = 4'($urandom_range(0, 15)) & {4{$urandom_range(0, 3) == 0}};
      rel2 = 4'($urandom_range(0, 15)) & {4{$urandom_range(0, 4) == 0}};
      @(posedge clk); #1;
      chk("rand_onehot0", 32'($onehot0(grant2)), 32'd1);
      chk("rand_busy", 32'(busy2), 32'(|grant2));
      chk("rand_pend_vs_grant", 32'(pending2 & grant2), 32'd0);
      chk("rand_owner", 32'((grant2 == 4'd0) || (grant2 == (4'd1 << owner2))), 32'd1);
      chk("rand_tpulse_nogrant", 32'(tpulse2 && (grant2 != 4'd0)), 32'd0);
      chk("rand_tcount_mono", 32'(tcount2 >= prev_tc2), 32'd1);
      prev_tc2 = tcount2;
    end
    $display("[TB] random run done, %0d revokes on 4-requester instance", tcount2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_buf_arbiter.md
Name: shared_buf_arbiter

Overview:
Round-robin grant/release arbiter that shares one single-ported resource among NUM_REQ requesters. Typical resources are the ROS2 app_data configuration block and the UDP RX buffer, and typical requesters are the HLS ros2 core and one or more CPU ports.
- Requesters issue single-cycle request and release pulses, using the HLS ap_vld style.
- The arbiter keeps exactly one owner at a time and returns a registered one-hot grant.
- A hold watchdog revokes ownership from a requester that never releases.
- Sits inside ros2_ether in the clk_int domain, replacing the ad-hoc per-resource arbiters.

Parameters:
- NUM_REQ, 2, number of requesters (2..8); index 0 has top priority after reset.
- HOLD_TIMEOUT, 4096, cycles an owner may hold the grant before forced revoke; 0 disables the watchdog.
- CNT_WIDTH, 16, width of the hold counter; HOLD_TIMEOUT must be < 2**CNT_WIDTH.

Ports:
- clk_int  in  1  core clock.
- rst_int  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-requester request pulse (a level is also accepted).
- rel  in  NUM_REQ  per-requester release pulse.
- grant  out  NUM_REQ  registered one-hot (or zero) ownership.
- busy  out  1  high while any grant is asserted.
- owner_id  out  3  index of the current owner; holds the last owner when idle.
- pending  out  NUM_REQ  latched outstanding requests.
- timeout_pulse  out  1  one-cycle pulse when the watchdog revokes a grant.
- timeout_count  out  8  saturating count of revokes.

Behaviour:
- Reset values:
  - grant=0, busy=0, owner_id=0, pending=0, timeout_pulse=0, timeout_count=0.
  - Round-robin pointer=0, hold counter=0, state=IDLE.
  - Reset mid-ownership drops the grant on the next edge; no release is required afterwards.
- States:
  - IDLE: no owner.
  - GRANTED: one owner.
  - GAP: single dead cycle after any release or revoke.
- Request latching:
  - pending[i] is set by req[i] in any state, except when i is the current owner in GRANTED; that request is dropped.
  - pending[i] is cleared in the cycle i is granted.
- IDLE:
  - Candidates are pending | req.
  - If any candidate exists, pick the first set bit searching upward from the pointer, wrapping at NUM_REQ-1 to 0.
  - Register grant = one-hot(winner), owner_id = winner, pointer = winner+1 mod NUM_REQ, go to GRANTED.
  - Latency: req pulse at cycle N in IDLE gives grant high at cycle N+1.
- GRANTED:
  - rel[owner]=1 gives grant=0 next cycle and a move to GAP.
  - rel from a non-owner is ignored and does not clear its pending bit.
  - Hold counter increments each cycle in GRANTED.
  - If HOLD_TIMEOUT≠0 and counter==HOLD_TIMEOUT-1 with no release: grant=0 next cycle, timeout_pulse=1 for that cycle, timeout_count+1 (saturate at 255), go to GAP.
  - Release wins over the watchdog in the same cycle; no timeout_pulse is generated.
- GAP:
  - grant=0 and the counter clears; go to IDLE.
  - Earliest next grant is 2 cycles after the release edge, so the old owner sees grant low before any new owner sees it high.
- Simultaneous events:
  - Simultaneous req and rel from the same non-owner index in IDLE: req is latched, rel is ignored.
  - Several simultaneous reqs: round-robin order. After reset with pointer=0, index 0 wins.
- busy = |grant; owner_id is registered together with grant.
- Invariant: $onehot0(grant) every cycle.

Test Plan:
- Reset, then req[1] pulse at cycle 10 -> grant=2'b10 at cycle 11, owner_id=1, pending=0; rel[1] at 20 -> grant=0 at 21, GAP at 21, IDLE at 22.
- req=2'b11 same cycle after reset -> grant 2'b01 first. rel[0], then grant 2'b10 exactly 2 cycles after rel, with no re-request needed from index 1. rel[1] followed by req=2'b11 again -> 2'b01 (pointer wrapped).
- HOLD_TIMEOUT=16, req[0] at cycle 5, never released -> grant high cycles 6..21, grant=0 at 22 with timeout_pulse=1 for exactly that cycle, timeout_count=1; index 0 not re-granted unless it requests again.
- Owner 0 asserts rel[0] on the same cycle the counter hits 15 (HOLD_TIMEOUT=16) -> grant drops with no timeout_pulse; timeout_count unchanged.
- While index 0 owns: rel[1] pulse -> no effect; req[0] pulse -> pending[0] stays 0; req[1] pulse -> pending[1]=1 and held until granted.
- Assert rst_int for 1 cycle while grant=2'b10 and pending=2'b01 -> all outputs 0 next cycle; a fresh req[1] is granted 1 cycle later. Assertion check: grant is onehot0 throughout a 10k-cycle random req/rel run with NUM_REQ=4.
